// File: rtl/ysyx_22050243_id_hazard_unit_pkg.sv
// ysyx_22050243_id_hazard_unit_pkg: opcode constants, forward-select encoding and operand-use decode for the ID hazard unit
package ysyx_22050243_id_hazard_unit_pkg;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10} fwd_e;
  function automatic logic uses_rs1(input logic [6:0] op);
    return op inside {OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM};
  endfunction
  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {OPC_BRANCH, OPC_STORE, OPC_OP};
  endfunction
  function automatic logic writes_rd(input logic [6:0] op);
    return op inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OP, OPC_OPIMM};
  endfunction
endpackage

// File: rtl/ysyx_22050243_scoreboard.sv
// ysyx_22050243_scoreboard: pending-write bit per GPR for long-latency ops; set/clear ports, rs1/rs2/rd read ports, busy flag
module ysyx_22050243_scoreboard #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic [AW-1:0] ra3,
  output logic          rd1,
  output logic          rd2,
  output logic          rd3,
  output logic          busy
);
  localparam int DEPTH = 2 ** AW;
  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_pend_nxt;
  // clear applied first so a same-index set wins; x0 is never tracked
  always_comb begin
    w_pend_nxt = r_pend;
    if (clr_en) w_pend_nxt[clr_idx] = 1'b0;
    if (set_en && set_idx != '0) w_pend_nxt[set_idx] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_pend <= '0;
    else r_pend <= w_pend_nxt;
  // reads see the pre-update vector, so a bit cleared this cycle still reads pending
  assign rd1  = r_pend[ra1];
  assign rd2  = r_pend[ra2];
  assign rd3  = r_pend[ra3];
  assign busy = |r_pend;
endmodule

// File: rtl/ysyx_22050243_id_hazard_unit.sv
// ysyx_22050243_id_hazard_unit: ID-stage stall/forward for ID-resolved JALR/BRANCH plus long-latency scoreboard and stall timeout
module ysyx_22050243_id_hazard_unit
  import ysyx_22050243_id_hazard_unit_pkg::*;
#(
  parameter int GPR_ADDR_WIDTH  = 5,
  parameter int IBUS_DATA_WIDTH = 32,
  parameter int BRANCH_IN_ID    = 1,
  parameter int STALL_CNT_WIDTH = 6,
  parameter int STALL_LIMIT     = 40
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IBUS_DATA_WIDTH-1:0] inst_if_2_id_ff,
  input  logic                       id_valid,
  input  logic [GPR_ADDR_WIDTH-1:0]  rd_id_2_ex_ff,
  input  logic                       reg_w_id_2_ex_ff,
  input  logic [GPR_ADDR_WIDTH-1:0]  rd_ex_2_mem_ff,
  input  logic                       reg_w_ex_2_mem_ff,
  input  logic                       mem_r_ex_2_mem_ff,
  input  logic [GPR_ADDR_WIDTH-1:0]  rd_mem_2_wb_ff,
  input  logic                       reg_w_mem_2_wb_ff,
  input  logic                       lop_issue,
  input  logic [GPR_ADDR_WIDTH-1:0]  lop_rd,
  input  logic                       lop_wb,
  input  logic [GPR_ADDR_WIDTH-1:0]  lop_wb_rd,
  output logic [1:0]                 fwd_rs1,
  output logic [1:0]                 fwd_rs2,
  output logic                       stall_id,
  output logic                       stall_timeout,
  output logic                       sb_busy
);
  localparam int AW = GPR_ADDR_WIDTH;
  logic [6:0] w_op;
  logic [AW-1:0] w_rs1, w_rs2, w_rd;
  logic w_unused;
  logic w_ctl1, w_ctl2, w_nz1, w_nz2, w_mem_alu, w_mem_ld;
  logic w_pend1, w_pend2, w_pend_rd;
  logic w_pst1, w_pst2, w_sst1, w_sst2, w_waw;
  fwd_e w_fwd1, w_fwd2;
  logic [STALL_CNT_WIDTH-1:0] r_stall_cnt, w_cnt_nxt;
  logic r_timeout;
  assign w_op     = inst_if_2_id_ff[6:0];
  assign w_rd     = inst_if_2_id_ff[7 +: AW];
  assign w_rs1    = inst_if_2_id_ff[15 +: AW];
  assign w_rs2    = inst_if_2_id_ff[20 +: AW];
  assign w_unused = ^inst_if_2_id_ff;
  assign w_ctl1    = w_op == OPC_JALR || (BRANCH_IN_ID != 0 && w_op == OPC_BRANCH);
  assign w_ctl2    = BRANCH_IN_ID != 0 && w_op == OPC_BRANCH;
  assign w_nz1     = |w_rs1;
  assign w_nz2     = |w_rs2;
  assign w_mem_alu = reg_w_ex_2_mem_ff && !mem_r_ex_2_mem_ff;
  assign w_mem_ld  = reg_w_ex_2_mem_ff && mem_r_ex_2_mem_ff;
  // a producer in EX, or a load in MEM, has no value yet that ID can forward
  assign w_pst1 = w_ctl1 && w_nz1 && ((w_rs1 == rd_id_2_ex_ff && reg_w_id_2_ex_ff) || (w_rs1 == rd_ex_2_mem_ff && w_mem_ld));
  assign w_pst2 = w_ctl2 && w_nz2 && ((w_rs2 == rd_id_2_ex_ff && reg_w_id_2_ex_ff) || (w_rs2 == rd_ex_2_mem_ff && w_mem_ld));
  assign w_fwd1 = !(id_valid && w_ctl1 && w_nz1) ? FWD_RF :
                  (w_rs1 == rd_ex_2_mem_ff && w_mem_alu) ? FWD_EXMEM :
                  (w_rs1 == rd_mem_2_wb_ff && reg_w_mem_2_wb_ff) ? FWD_MEMWB : FWD_RF;
  assign w_fwd2 = !(id_valid && w_ctl2 && w_nz2) ? FWD_RF :
                  (w_rs2 == rd_ex_2_mem_ff && w_mem_alu) ? FWD_EXMEM :
                  (w_rs2 == rd_mem_2_wb_ff && reg_w_mem_2_wb_ff) ? FWD_MEMWB : FWD_RF;
  assign fwd_rs1 = w_fwd1;
  assign fwd_rs2 = w_fwd2;
  ysyx_22050243_scoreboard #(.AW(AW)) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (lop_issue),
    .set_idx (lop_rd),
    .clr_en  (lop_wb),
    .clr_idx (lop_wb_rd),
    .ra1     (w_rs1),
    .ra2     (w_rs2),
    .ra3     (w_rd),
    .rd1     (w_pend1),
    .rd2     (w_pend2),
    .rd3     (w_pend_rd),
    .busy    (sb_busy)
  );
  assign w_sst1   = uses_rs1(w_op) && w_nz1 && w_pend1;
  assign w_sst2   = uses_rs2(w_op) && w_nz2 && w_pend2;
  assign w_waw    = writes_rd(w_op) && |w_rd && w_pend_rd;
  assign stall_id = id_valid && (w_pst1 || w_pst2 || w_sst1 || w_sst2 || w_waw);
  assign w_cnt_nxt = !stall_id ? '0 : (&r_stall_cnt) ? r_stall_cnt : r_stall_cnt + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_stall_cnt <= w_cnt_nxt;
      r_timeout   <= r_timeout || w_cnt_nxt == STALL_CNT_WIDTH'(STALL_LIMIT);
    end
  assign stall_timeout = r_timeout;
endmodule

// File: tb/tb_ysyx_22050243_id_hazard_unit.sv
// tb_ysyx_22050243_id_hazard_unit: directed scenarios plus randomized cycles checked against a rule-level reference model
module tb_ysyx_22050243_id_hazard_unit;
  localparam logic [6:0] LUI = 7'b0110111, JAL = 7'b1101111, JALR = 7'b1100111, BR = 7'b1100011;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, OP = 7'b0110011, OPI = 7'b0010011;
  localparam int LIMIT = 40;
  logic clk = 0, rst = 1;
  logic [31:0] inst;
  logic id_valid, w_ex, w_mem, mr, w_wb, lop_issue, lop_wb;
  logic [4:0] rd_ex, rd_mem, rd_wb, lop_rd, lop_wb_rd;
  logic [1:0] fwd1, fwd2, fwd1_0, fwd2_0;
  logic stall, tmo, busy, stall_0, tmo_0, busy_0;
  int n_tests = 0, n_fail = 0;
  bit pend [32];
  int m_cnt;
  bit m_tmo;
  always #5 clk = ~clk;
  ysyx_22050243_id_hazard_unit dut (
    .clk(clk), .rst(rst), .inst_if_2_id_ff(inst), .id_valid(id_valid),
    .rd_id_2_ex_ff(rd_ex), .reg_w_id_2_ex_ff(w_ex), .rd_ex_2_mem_ff(rd_mem),
    .reg_w_ex_2_mem_ff(w_mem), .mem_r_ex_2_mem_ff(mr), .rd_mem_2_wb_ff(rd_wb),
    .reg_w_mem_2_wb_ff(w_wb), .lop_issue(lop_issue), .lop_rd(lop_rd), .lop_wb(lop_wb),
    .lop_wb_rd(lop_wb_rd), .fwd_rs1(fwd1), .fwd_rs2(fwd2), .stall_id(stall),
    .stall_timeout(tmo), .sb_busy(busy));
  ysyx_22050243_id_hazard_unit #(.BRANCH_IN_ID(0)) dut0 (
    .clk(clk), .rst(rst), .inst_if_2_id_ff(inst), .id_valid(id_valid),
    .rd_id_2_ex_ff(rd_ex), .reg_w_id_2_ex_ff(w_ex), .rd_ex_2_mem_ff(rd_mem),
    .reg_w_ex_2_mem_ff(w_mem), .mem_r_ex_2_mem_ff(mr), .rd_mem_2_wb_ff(rd_wb),
    .reg_w_mem_2_wb_ff(w_wb), .lop_issue(lop_issue), .lop_rd(lop_rd), .lop_wb(lop_wb),
    .lop_wb_rd(lop_wb_rd), .fwd_rs1(fwd1_0), .fwd_rs2(fwd2_0), .stall_id(stall_0),
    .stall_timeout(tmo_0), .sb_busy(busy_0));
  function automatic logic [31:0] mk(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction
  task automatic idle();
    inst = 32'h13; id_valid = 0; w_ex = 0; w_mem = 0; mr = 0; w_wb = 0;
    rd_ex = 0; rd_mem = 0; rd_wb = 0; lop_issue = 0; lop_rd = 0; lop_wb = 0; lop_wb_rd = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    idle();
    rst = 1;
    #2 rst = 0;
  endtask
  function automatic void model_eval(input bit bid, output logic [1:0] f1, output logic [1:0] f2, output logic st);
    logic [4:0] rs [1:2];
    logic [1:0] f [1:2];
    logic [6:0] op = inst[6:0];
    logic [4:0] rd = inst[11:7];
    bit uses [1:2];
    bit ctl [1:2];
    st = 0;
    rs[1] = inst[19:15];
    rs[2] = inst[24:20];
    uses[1] = op inside {JALR, BR, LD, ST, OP, OPI};
    uses[2] = op inside {BR, ST, OP};
    ctl[1] = op == JALR || (bid && op == BR);
    ctl[2] = bid && op == BR;
    for (int n = 1; n <= 2; n++) begin
      f[n] = 2'b00;
      if (rs[n] != 0) begin
        if (ctl[n]) begin
          if ((rs[n] == rd_ex && w_ex) || (rs[n] == rd_mem && w_mem && mr)) st = 1;
          if (rs[n] == rd_mem && w_mem && !mr) f[n] = 2'b01;
          else if (rs[n] == rd_wb && w_wb) f[n] = 2'b10;
        end
        if (uses[n] && pend[rs[n]]) st = 1;
      end
    end
    if (op inside {LUI, 7'b0010111, JAL, JALR, LD, OP, OPI} && rd != 0 && pend[rd]) st = 1;
    f1 = id_valid ? f[1] : 2'b00;
    f2 = id_valid ? f[2] : 2'b00;
    st = id_valid && st;
  endfunction
  task automatic test_reset();
    idle();
    rst = 1;
    #1;
    n_tests++; if (fwd1 !== 2'b00 || fwd2 !== 2'b00) begin n_fail++; $display("FAIL reset_fwd got=%b/%b exp=00/00", fwd1, fwd2); end
    n_tests++; if (stall !== 0 || stall_0 !== 0) begin n_fail++; $display("FAIL reset_stall got=%b/%b exp=0/0", stall, stall_0); end
    n_tests++; if (tmo !== 0 || tmo_0 !== 0) begin n_fail++; $display("FAIL reset_timeout got=%b/%b exp=0/0", tmo, tmo_0); end
    n_tests++; if (busy !== 0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst = 0;
  endtask
  task automatic test_jalr_fwd();
    do_reset();
    inst = mk(JALR, 1, 5, 0); id_valid = 1; rd_ex = 5; w_ex = 1;
    #1;
    n_tests++; if (stall !== 1 || fwd1 !== 2'b00) begin n_fail++; $display("FAIL jalr_ex_stall got=%b/%b exp=1/00", stall, fwd1); end
    n_tests++; if (stall_0 !== 1) begin n_fail++; $display("FAIL jalr_ex_stall_b0 got=%b exp=1", stall_0); end
    tick();
    rd_ex = 0; w_ex = 0; rd_mem = 5; w_mem = 1;
    #1;
    n_tests++; if (stall !== 0 || fwd1 !== 2'b01) begin n_fail++; $display("FAIL jalr_mem_fwd got=%b/%b exp=0/01", stall, fwd1); end
    n_tests++; if (fwd1_0 !== 2'b01) begin n_fail++; $display("FAIL jalr_mem_fwd_b0 got=%b exp=01", fwd1_0); end
  endtask
  task automatic test_branch_load();
    do_reset();
    inst = mk(BR, 0, 3, 4); id_valid = 1; rd_mem = 3; w_mem = 1; mr = 1; rd_wb = 4; w_wb = 1;
    #1;
    n_tests++; if (stall !== 1 || fwd2 !== 2'b10) begin n_fail++; $display("FAIL br_load_stall got=%b/%b exp=1/10", stall, fwd2); end
    n_tests++; if (stall_0 !== 0 || fwd1_0 !== 2'b00 || fwd2_0 !== 2'b00) begin n_fail++; $display("FAIL br_b0 got=%b/%b/%b exp=0/00/00", stall_0, fwd1_0, fwd2_0); end
    tick();
    rd_mem = 0; w_mem = 0; mr = 0; rd_wb = 3;
    #1;
    n_tests++; if (stall !== 0 || fwd1 !== 2'b10 || fwd2 !== 2'b00) begin n_fail++; $display("FAIL br_wb_fwd got=%b/%b/%b exp=0/10/00", stall, fwd1, fwd2); end
    n_tests++; if (fwd1_0 !== 2'b00) begin n_fail++; $display("FAIL br_wb_fwd_b0 got=%b exp=00", fwd1_0); end
  endtask
  task automatic test_lop_stall();
    do_reset();
    lop_issue = 1; lop_rd = 7;
    tick();
    lop_issue = 0; inst = mk(OP, 1, 7, 2); id_valid = 1;
    #1;
    n_tests++; if (stall !== 1 || busy !== 1) begin n_fail++; $display("FAIL lop_pending got=%b/%b exp=1/1", stall, busy); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (stall !== 1) begin n_fail++; $display("FAIL lop_hold got=%b exp=1", stall); end
    end
    lop_wb = 1; lop_wb_rd = 7;
    #1;
    n_tests++; if (stall !== 1) begin n_fail++; $display("FAIL lop_wb_bypass got=%b exp=1", stall); end
    tick();
    lop_wb = 0;
    #1;
    n_tests++; if (stall !== 0 || busy !== 0) begin n_fail++; $display("FAIL lop_released got=%b/%b exp=0/0", stall, busy); end
    lop_issue = 1; id_valid = 0;
    tick();
    lop_issue = 0; id_valid = 1; inst = mk(OP, 1, 2, 7);
    #1;
    n_tests++; if (stall !== 1) begin n_fail++; $display("FAIL lop_rs2 got=%b exp=1", stall); end
    inst = mk(OPI, 7, 2, 0);
    #1;
    n_tests++; if (stall !== 1) begin n_fail++; $display("FAIL lop_waw got=%b exp=1", stall); end
    inst = mk(LD, 3, 2, 7);
    #1;
    n_tests++; if (stall !== 0) begin n_fail++; $display("FAIL load_no_rs2 got=%b exp=0", stall); end
    inst = mk(ST, 0, 2, 7);
    #1;
    n_tests++; if (stall !== 1) begin n_fail++; $display("FAIL store_rs2 got=%b exp=1", stall); end
    id_valid = 0;
    #1;
    n_tests++; if (stall !== 0) begin n_fail++; $display("FAIL invalid_no_stall got=%b exp=0", stall); end
  endtask
  task automatic test_same_cycle_zero();
    do_reset();
    lop_issue = 1; lop_rd = 9; lop_wb = 1; lop_wb_rd = 9;
    tick();
    idle();
    inst = mk(OP, 1, 9, 0); id_valid = 1;
    #1;
    n_tests++; if (stall !== 1 || busy !== 1) begin n_fail++; $display("FAIL set_wins got=%b/%b exp=1/1", stall, busy); end
    lop_wb = 1; lop_wb_rd = 9;
    tick();
    lop_wb = 0; lop_issue = 1; lop_rd = 0;
    tick();
    lop_issue = 0; inst = mk(OP, 0, 0, 0);
    #1;
    n_tests++; if (busy !== 0 || stall !== 0) begin n_fail++; $display("FAIL x0_never_set got=%b/%b exp=0/0", busy, stall); end
    inst = mk(JALR, 0, 0, 0); rd_ex = 0; w_ex = 1; rd_mem = 0; w_mem = 1; rd_wb = 0; w_wb = 1;
    #1;
    n_tests++; if (stall !== 0 || fwd1 !== 2'b00) begin n_fail++; $display("FAIL x0_pipe got=%b/%b exp=0/00", stall, fwd1); end
  endtask
  task automatic test_timeout();
    do_reset();
    lop_issue = 1; lop_rd = 7;
    tick();
    lop_issue = 0; inst = mk(OP, 1, 7, 0); id_valid = 1;
    for (int i = 1; i <= LIMIT; i++) begin
      #1;
      n_tests++; if (tmo !== 0) begin n_fail++; $display("FAIL timeout_early cyc=%0d got=%b exp=0", i, tmo); end
      tick();
    end
    #1;
    n_tests++; if (tmo !== 1) begin n_fail++; $display("FAIL timeout_set got=%b exp=1", tmo); end
    lop_wb = 1; lop_wb_rd = 7;
    tick();
    lop_wb = 0;
    #1;
    n_tests++; if (stall !== 0 || tmo !== 1) begin n_fail++; $display("FAIL timeout_sticky got=%b/%b exp=0/1", stall, tmo); end
    tick();
    idle();
    rst = 1;
    #1;
    n_tests++; if (tmo !== 0 || stall !== 0 || busy !== 0 || fwd1 !== 0 || fwd2 !== 0) begin n_fail++; $display("FAIL timeout_rst got=%b%b%b%b%b exp=00000", tmo, stall, busy, fwd1, fwd2); end
    @(negedge clk);
    rst = 0;
  endtask
  task automatic test_random();
    logic [6:0] ops [8] = '{JALR, BR, LD, ST, OP, OPI, LUI, JAL};
    logic [1:0] e1, e2, e1_0, e2_0;
    logic es, es_0;
    bit any;
    do_reset();
    foreach (pend[i]) pend[i] = 0;
    m_cnt = 0; m_tmo = 0;
    for (int c = 0; c < 400; c++) begin
      inst = mk(ops[$urandom_range(7)], 5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)));
      inst[31:25] = 7'($urandom);
      id_valid = $urandom_range(3) != 0;
      rd_ex = 5'($urandom_range(7)); w_ex = 1'($urandom);
      rd_mem = 5'($urandom_range(7)); w_mem = 1'($urandom); mr = 1'($urandom);
      rd_wb = 5'($urandom_range(7)); w_wb = 1'($urandom);
      lop_issue = $urandom_range(7) == 0; lop_rd = 5'($urandom_range(7));
      lop_wb = $urandom_range(2) == 0; lop_wb_rd = 5'($urandom_range(7));
      #1;
      model_eval(1, e1, e2, es);
      model_eval(0, e1_0, e2_0, es_0);
      any = 0;
      foreach (pend[i]) any |= pend[i];
      n_tests++; if (fwd1 !== e1 || fwd2 !== e2) begin n_fail++; $display("FAIL rnd_fwd c=%0d inst=%h got=%b/%b exp=%b/%b", c, inst, fwd1, fwd2, e1, e2); end
      n_tests++; if (stall !== es) begin n_fail++; $display("FAIL rnd_stall c=%0d inst=%h got=%b exp=%b", c, inst, stall, es); end
      n_tests++; if (fwd1_0 !== e1_0 || fwd2_0 !== e2_0 || stall_0 !== es_0) begin n_fail++; $display("FAIL rnd_b0 c=%0d got=%b/%b/%b exp=%b/%b/%b", c, fwd1_0, fwd2_0, stall_0, e1_0, e2_0, es_0); end
      n_tests++; if (busy !== any || busy_0 !== any) begin n_fail++; $display("FAIL rnd_busy c=%0d got=%b/%b exp=%b", c, busy, busy_0, any); end
      n_tests++; if (tmo !== m_tmo) begin n_fail++; $display("FAIL rnd_timeout c=%0d got=%b exp=%b", c, tmo, m_tmo); end
      @(posedge clk);
      if (lop_wb) pend[lop_wb_rd] = 0;
      if (lop_issue && lop_rd != 0) pend[lop_rd] = 1;
      m_cnt = es ? (m_cnt == 63 ? 63 : m_cnt + 1) : 0;
      if (m_cnt == LIMIT) m_tmo = 1;
      @(negedge clk);
    end
  endtask
  initial begin
    test_reset();
    test_jalr_fwd();
    test_branch_load();
    test_lop_stall();
    test_same_cycle_zero();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
